// File: rtl/fft_seq_pkg.sv
// ============================================================================
//  fft_seq_pkg : shared types, default widths and sink packing helper
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_seq_pkg;

  localparam int DEF_FFT_POINTS   = 256;
  localparam int DEF_IDX_W        = 8;
  localparam int DEF_SMP_W        = 15;
  localparam int DEF_OUT_W        = 39;
  localparam int DEF_MAX_INFLIGHT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    PAD  = 2'd2
  } feed_state_t;

  // Real sample goes in the upper (re) half, imaginary half is zero.
  function automatic logic [2*DEF_SMP_W-1:0] pack_sink(input logic [DEF_SMP_W-1:0] smp,
                                                       input logic                 pad);
    return pad ? '0 : {smp, {DEF_SMP_W{1'b0}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_seq_drain.sv
// ============================================================================
//  fft_seq_drain : result-side tracking (bin index, frame_done, error, stats)
//  Build option  : FFT_SEQ_STATS_EN enables err_count / frame_count registers
//  Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_seq_drain
  import fft_seq_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic             src_sop,
  input  logic             src_eop,
  input  logic [1:0]       src_error,
  input  logic [OUT_W-1:0] src_data,
  input  logic             inflight_zero,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [OUT_W-1:0] bin_data,
  output logic [IDX_W-1:0] bin_index,
  output logic             frame_done,
  output logic             err_flag,
  output logic [7:0]       err_count,
  output logic [7:0]       frame_count
);

  logic             fire;
  logic [IDX_W-1:0] next_idx;

  assign fire      = src_valid & bin_ready;
  assign src_ready = bin_ready;
  assign bin_valid = src_valid;
  assign bin_data  = src_data;
  assign bin_index = src_sop ? '0 : next_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      next_idx   <= '0;
      frame_done <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      frame_done <= fire & src_eop;
      if (fire) begin
        next_idx <= bin_index + IDX_W'(1);
        // An end-of-packet with nothing outstanding means the core and feeder disagree.
        if ((src_error != 2'b00) || (src_eop && inflight_zero))
          err_flag <= 1'b1;
      end
    end
  end

`ifdef FFT_SEQ_STATS_EN
  logic [7:0] err_cnt_q;
  logic [7:0] frm_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      if (fire && (src_error != 2'b00) && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
      if (fire && src_eop)
        frm_cnt_q <= frm_cnt_q + 8'd1;
    end
  end

  assign err_count   = err_cnt_q;
  assign frame_count = frm_cnt_q;
`else
  assign err_count   = '0;
  assign frame_count = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
// ============================================================================
//  fft_frame_sequencer : frames samples into FFT packets, tracks results
//  Build option        : FFT_SEQ_STATS_EN (statistics counters in drain)
//  Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FFT_POINTS   = DEF_FFT_POINTS,
  parameter int IDX_W        = DEF_IDX_W,
  parameter int SMP_W        = DEF_SMP_W,
  parameter int OUT_W        = DEF_OUT_W,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start,
  input  logic               cont_mode,
  input  logic               abort,
  input  logic               smp_valid,
  output logic               smp_ready,
  input  logic [SMP_W-1:0]   smp_data,
  output logic               sink_valid,
  input  logic               sink_ready,
  output logic               sink_sop,
  output logic               sink_eop,
  output logic [1:0]         sink_error,
  output logic [2*SMP_W-1:0] sink_data,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic               src_sop,
  input  logic               src_eop,
  input  logic [1:0]         src_error,
  input  logic [OUT_W-1:0]   src_data,
  output logic               bin_valid,
  input  logic               bin_ready,
  output logic [OUT_W-1:0]   bin_data,
  output logic [IDX_W-1:0]   bin_index,
  output logic               frame_done,
  output logic               busy,
  output logic               err_flag,
  output logic [7:0]         err_count,
  output logic [7:0]         frame_count
);

  feed_state_t      state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [1:0]       inflight, inflight_nxt;
  logic             sink_fire, last_beat, sink_eop_fire, src_eop_fire, padding;

  assign padding       = (state == PAD);
  assign sink_valid    = (state == FEED) ? smp_valid : padding;
  assign smp_ready     = (state == FEED) & sink_ready;
  assign sink_fire     = sink_valid & sink_ready;
  assign last_beat     = (cnt == IDX_W'(FFT_POINTS - 1));
  assign sink_eop_fire = sink_fire & last_beat;
  assign src_eop_fire  = src_valid & src_ready & src_eop;
  assign sink_error    = 2'b00;

  // A stray result EOP with nothing outstanding must not underflow the count.
  always_comb begin
    inflight_nxt = inflight;
    if (sink_eop_fire && !(src_eop_fire && inflight != 2'd0))
      inflight_nxt = inflight + 2'd1;
    else if (!sink_eop_fire && src_eop_fire && inflight != 2'd0)
      inflight_nxt = inflight - 2'd1;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if ((start || cont_mode) && inflight < 2'(MAX_INFLIGHT)) state_nxt = FEED;
      FEED: begin
        if (sink_eop_fire)
          state_nxt = (cont_mode && inflight_nxt < 2'(MAX_INFLIGHT)) ? FEED : IDLE;
        else if (abort)
          state_nxt = PAD;
      end
      PAD: begin
        if (sink_eop_fire)
          state_nxt = (cont_mode && inflight_nxt < 2'(MAX_INFLIGHT)) ? FEED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (sink_fire)
      cnt_nxt = last_beat ? '0 : cnt + IDX_W'(1);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      inflight <= '0;
      sink_sop <= 1'b0;
      sink_eop <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      inflight <= inflight_nxt;
      sink_sop <= (state_nxt != IDLE) && (cnt_nxt == '0);
      sink_eop <= (state_nxt != IDLE) && (cnt_nxt == IDX_W'(FFT_POINTS - 1));
      busy     <= (state_nxt != IDLE) || (inflight_nxt != 2'd0);
    end
  end

  generate
    if (SMP_W == DEF_SMP_W) begin : g_pack_fn
      assign sink_data = pack_sink(smp_data, padding);
    end else begin : g_pack_inline
      assign sink_data = padding ? '0 : {smp_data, {SMP_W{1'b0}}};
    end
  endgenerate

  fft_seq_drain #(
    .IDX_W (IDX_W),
    .OUT_W (OUT_W)
  ) u_drain (
    .clk           (clk_clk),
    .reset_n       (reset_reset_n),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_sop       (src_sop),
    .src_eop       (src_eop),
    .src_error     (src_error),
    .src_data      (src_data),
    .inflight_zero (inflight == 2'd0),
    .bin_valid     (bin_valid),
    .bin_ready     (bin_ready),
    .bin_data      (bin_data),
    .bin_index     (bin_index),
    .frame_done    (frame_done),
    .err_flag      (err_flag),
    .err_count     (err_count),
    .frame_count   (frame_count)
  );

endmodule

`default_nettype wire
